// File: rtl/crypto_job_scheduler.sv
// crypto_job_scheduler
//   Shares one crypto engine between NREQ requesters, one job at a time.
//   Round-robin arbitration picks the next owner; the FSM pulses START, watches
//   BUSY/COMPLETE and the engine error flags, enforces start/run/drain timeouts,
//   pulses PURGE on failure or abort, and reports a result code to the owner.
//
// Ports
//   HCLK, HRESETN   clock, asynchronous active-low reset
//   req             level job request per requester
//   abort           abort request; only the owner's bit counts, only in RUN
//   stall_req       per-requester stall, forwarded to STALL for the owner
//   gnt, owner      one-hot grant and its index, held from START through REPORT
//   done, status    one-cycle completion pulse to the owner, result code
//   fatal           sticky drain-timeout flag, cleared by fatal_clr
//   START, PURGE    one-cycle pulses to the engine
//   STALL           stall_req of the owner while granted
//   BUSY, COMPLETE, ALARM, BUS_ERROR   engine status inputs
//
// Result codes: 0 ok, 1 start timeout, 2 alarm, 3 bus error, 4 run timeout,
//   5 abort, 6 drain timeout.

module crypto_job_scheduler #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned START_TO = 16,
    parameter int unsigned RUN_TO   = 65535,
    parameter int unsigned DRAIN_TO = 256
) (
    input  logic            HCLK,
    input  logic            HRESETN,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] abort,
    input  logic [NREQ-1:0] stall_req,
    output logic [NREQ-1:0] gnt,
    output logic [2:0]      owner,
    output logic [NREQ-1:0] done,
    output logic [2:0]      status,
    output logic            fatal,
    input  logic            fatal_clr,
    output logic            START,
    output logic            PURGE,
    output logic            STALL,
    input  logic            BUSY,
    input  logic            COMPLETE,
    input  logic            ALARM,
    input  logic            BUS_ERROR
);

    localparam int unsigned MAX_SR = (START_TO > RUN_TO) ? START_TO : RUN_TO;
    localparam int unsigned MAX_TO = (MAX_SR > DRAIN_TO) ? MAX_SR : DRAIN_TO;
    localparam int unsigned CW     = $clog2(MAX_TO) + 1;

    localparam logic [CW-1:0]   START_LIM = CW'(START_TO - 1);
    localparam logic [CW-1:0]   RUN_LIM   = CW'(RUN_TO - 1);
    localparam logic [CW-1:0]   DRAIN_LIM = CW'(DRAIN_TO - 1);
    localparam logic [NREQ-1:0] ONE       = NREQ'(1);

    localparam logic [2:0] CODE_OK       = 3'd0;
    localparam logic [2:0] CODE_START_TO = 3'd1;
    localparam logic [2:0] CODE_ALARM    = 3'd2;
    localparam logic [2:0] CODE_BUS_ERR  = 3'd3;
    localparam logic [2:0] CODE_RUN_TO   = 3'd4;
    localparam logic [2:0] CODE_ABORT    = 3'd5;
    localparam logic [2:0] CODE_DRAIN_TO = 3'd6;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitBusy,
        StRun,
        StPurge,
        StDrain,
        StReport
    } state_e;

    state_e          state;
    logic [2:0]      rr;
    logic [2:0]      code;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [2:0]      rr_next;
    logic [NREQ-1:0] req_hi;
    logic            pick_valid;
    logic [2:0]      pick_idx;
    logic            owner_abort;

    // Saturating cycle counter shared by all timed states.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    assign rr_next = (owner == 3'(NREQ - 1)) ? 3'd0 : owner + 3'd1;

    // gnt is one-hot, so masking with it selects the owner's bit.
    assign owner_abort = |(abort & gnt);
    assign STALL       = |(stall_req & gnt);

    // Requests at or above the round-robin pointer.
    assign req_hi = req & ~((ONE << rr) - ONE);

    // Lowest set bit of req_hi if any, otherwise lowest set bit of req
    // (i.e. first request at/after rr, wrapping).
    always_comb begin
        pick_valid = |req;
        pick_idx   = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_idx = 3'(i);
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_hi[i]) begin
                pick_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state  <= StIdle;
            gnt    <= '0;
            owner  <= '0;
            done   <= '0;
            status <= '0;
            fatal  <= 1'b0;
            START  <= 1'b0;
            PURGE  <= 1'b0;
            rr     <= '0;
            cnt    <= '0;
            code   <= '0;
        end else begin
            START <= 1'b0;
            PURGE <= 1'b0;
            done  <= '0;
            // A drain timeout later in this block overrides the clear.
            if (fatal_clr) begin
                fatal <= 1'b0;
            end

            unique case (state)
                StIdle: begin
                    if (pick_valid && !BUSY && !fatal) begin
                        gnt   <= ONE << pick_idx;
                        owner <= pick_idx;
                        START <= 1'b1;
                        state <= StStart;
                    end
                end

                StStart: begin
                    cnt   <= '0;
                    state <= StWaitBusy;
                end

                StWaitBusy: begin
                    if (COMPLETE) begin
                        done   <= gnt;
                        status <= CODE_OK;
                        state  <= StReport;
                    end else if (BUSY) begin
                        cnt   <= '0;
                        state <= StRun;
                    end else if (cnt == START_LIM) begin
                        code  <= CODE_START_TO;
                        PURGE <= 1'b1;
                        state <= StPurge;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                StRun: begin
                    if (BUS_ERROR) begin
                        code  <= CODE_BUS_ERR;
                        PURGE <= 1'b1;
                        state <= StPurge;
                    end else if (ALARM) begin
                        code  <= CODE_ALARM;
                        PURGE <= 1'b1;
                        state <= StPurge;
                    end else if (COMPLETE) begin
                        done   <= gnt;
                        status <= CODE_OK;
                        state  <= StReport;
                    end else if (cnt == RUN_LIM) begin
                        code  <= CODE_RUN_TO;
                        PURGE <= 1'b1;
                        state <= StPurge;
                    end else if (owner_abort) begin
                        code  <= CODE_ABORT;
                        PURGE <= 1'b1;
                        state <= StPurge;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                StPurge: begin
                    cnt   <= '0;
                    state <= StDrain;
                end

                StDrain: begin
                    if (!BUSY) begin
                        done   <= gnt;
                        status <= code;
                        state  <= StReport;
                    end else if (cnt == DRAIN_LIM) begin
                        fatal  <= 1'b1;
                        done   <= gnt;
                        status <= CODE_DRAIN_TO;
                        state  <= StReport;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                StReport: begin
                    gnt   <= '0;
                    owner <= '0;
                    rr    <= rr_next;
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_job_scheduler.sv
// Testbench for crypto_job_scheduler: randomized jobs against a round-robin /
// result-code reference model, with a scoreboard checked by a done monitor.

module tb_crypto_job_scheduler;

    localparam int NREQ     = 3;
    localparam int START_TO = 16;
    localparam int RUN_TO   = 64;
    localparam int DRAIN_TO = 256;

    localparam int ScOk         = 0;
    localparam int ScFast       = 1;
    localparam int ScStartTo    = 2;
    localparam int ScAlarm      = 3;
    localparam int ScBus        = 4;
    localparam int ScRunTo      = 5;
    localparam int ScAbort      = 6;
    localparam int ScAbortOther = 7;
    localparam int ScDrainTo    = 8;

    localparam int EvStart = 0;
    localparam int EvPurge = 1;
    localparam int EvDone  = 2;

    logic            HCLK;
    logic            HRESETN;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] abort;
    logic [NREQ-1:0] stall_req;
    logic [NREQ-1:0] gnt;
    logic [2:0]      owner;
    logic [NREQ-1:0] done;
    logic [2:0]      status;
    logic            fatal;
    logic            fatal_clr;
    logic            START;
    logic            PURGE;
    logic            STALL;
    logic            BUSY;
    logic            COMPLETE;
    logic            ALARM;
    logic            BUS_ERROR;

    crypto_job_scheduler #(
        .NREQ    (NREQ),
        .START_TO(START_TO),
        .RUN_TO  (RUN_TO),
        .DRAIN_TO(DRAIN_TO)
    ) dut (
        .HCLK     (HCLK),
        .HRESETN  (HRESETN),
        .req      (req),
        .abort    (abort),
        .stall_req(stall_req),
        .gnt      (gnt),
        .owner    (owner),
        .done     (done),
        .status   (status),
        .fatal    (fatal),
        .fatal_clr(fatal_clr),
        .START    (START),
        .PURGE    (PURGE),
        .STALL    (STALL),
        .BUSY     (BUSY),
        .COMPLETE (COMPLETE),
        .ALARM    (ALARM),
        .BUS_ERROR(BUS_ERROR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct packed {
        logic [2:0] owner;
        logic [2:0] code;
        logic       fatal;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_rr = 0;

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: first requester at/after the pointer, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (model_rr + k) % NREQ;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [2:0] code_of(input int sc);
        case (sc)
            ScStartTo: return 3'd1;
            ScAlarm:   return 3'd2;
            ScBus:     return 3'd3;
            ScRunTo:   return 3'd4;
            ScAbort:   return 3'd5;
            ScDrainTo: return 3'd6;
            default:   return 3'd0;
        endcase
    endfunction

    function automatic bit ev(input int sel);
        case (sel)
            EvStart: return START;
            EvPurge: return PURGE;
            default: return done != '0;
        endcase
    endfunction

    // Checks the current negedge first, then advances; a miss stops the run.
    task automatic wait_ev(input int sel, input int lim, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < lim; c++) begin
            if (ev(sel)) begin
                ok = 1'b1;
                break;
            end
            @(negedge HCLK);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout_%s: event absent after %0d cycles, required present", name, lim);
            summary();
            $fatal(1);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge HCLK) begin
        if (HRESETN && done != '0) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL done_unexpected: got done=0x%0h, required no done", done);
            end else begin
                mon_e = sb.pop_front();
                check("done_onehot", 32'(done), 32'(1) << mon_e.owner);
                check("status", 32'(status), 32'(mon_e.code));
                check("fatal_at_done", 32'(fatal), 32'(mon_e.fatal));
            end
        end
    end

    task automatic raise_busy();
        repeat ($urandom_range(1, 12)) @(negedge HCLK);
        BUSY = 1'b1;
        repeat ($urandom_range(2, 20)) @(negedge HCLK);
    endtask

    task automatic drop_busy_later();
        repeat ($urandom_range(0, 10)) @(negedge HCLK);
        BUSY = 1'b0;
    endtask

    task automatic run_job(input logic [NREQ-1:0] m, input int sc);
        exp_t e;
        int   own;
        own     = model_pick(m);
        e.owner = 3'(own);
        e.code  = code_of(sc);
        e.fatal = (sc == ScDrainTo);
        sb.push_back(e);
        model_rr  = (own + 1) % NREQ;
        stall_req = NREQ'($urandom);
        req       = m;
        wait_ev(EvStart, 10, "start");
        check("gnt", 32'(gnt), 32'(1) << own);
        check("owner", 32'(owner), 32'(own));
        req = '0;
        case (sc)
            ScOk: begin
                raise_busy();
                check("stall", 32'(STALL), 32'(stall_req[own]));
                COMPLETE = 1'b1;
                @(negedge HCLK);
                COMPLETE = 1'b0;
                BUSY     = 1'b0;
            end
            ScFast: begin
                repeat ($urandom_range(1, 12)) @(negedge HCLK);
                COMPLETE = 1'b1;
                BUSY     = 1'($urandom);
                @(negedge HCLK);
                COMPLETE = 1'b0;
                BUSY     = 1'b0;
            end
            ScStartTo: begin
                wait_ev(EvPurge, START_TO + 5, "start_to_purge");
            end
            ScAlarm, ScBus, ScDrainTo: begin
                raise_busy();
                ALARM     = (sc != ScBus) ? 1'b1 : 1'($urandom);
                BUS_ERROR = (sc == ScBus);
                COMPLETE  = 1'($urandom);
                @(negedge HCLK);
                ALARM     = 1'b0;
                BUS_ERROR = 1'b0;
                COMPLETE  = 1'b0;
                wait_ev(EvPurge, 3, "err_purge");
                if (sc != ScDrainTo) drop_busy_later();
            end
            ScRunTo: begin
                raise_busy();
                wait_ev(EvPurge, RUN_TO + 10, "run_to_purge");
                drop_busy_later();
            end
            ScAbort: begin
                raise_busy();
                abort = NREQ'($urandom) | (NREQ'(1) << own);
                @(negedge HCLK);
                abort = '0;
                wait_ev(EvPurge, 3, "abort_purge");
                drop_busy_later();
            end
            default: begin
                raise_busy();
                abort = (NREQ'($urandom) | (NREQ'(1) << ((own + 1) % NREQ)))
                        & ~(NREQ'(1) << own);
                repeat (3) @(negedge HCLK);
                abort    = '0;
                COMPLETE = 1'b1;
                @(negedge HCLK);
                COMPLETE = 1'b0;
                BUSY     = 1'b0;
            end
        endcase
        wait_ev(EvDone, DRAIN_TO + 40, "done");
        BUSY = 1'b0;
        @(negedge HCLK);
    endtask

    function automatic logic [NREQ-1:0] rand_mask();
        return NREQ'($urandom_range(1, (1 << NREQ) - 1));
    endfunction

    initial begin
        HRESETN   = 1'b0;
        req       = '0;
        abort     = '0;
        stall_req = '0;
        fatal_clr = 1'b0;
        BUSY      = 1'b0;
        COMPLETE  = 1'b0;
        ALARM     = 1'b0;
        BUS_ERROR = 1'b0;
        repeat (3) @(negedge HCLK);
        check("reset_outputs", 32'({gnt, owner, done, status, fatal, START, PURGE, STALL}), 0);
        HRESETN = 1'b1;
        @(negedge HCLK);
        check("idle_outputs", 32'({gnt, owner, done, status, fatal, START, PURGE, STALL}), 0);

        // All requesters asserted: grants must rotate 0,1,2,0.
        for (int j = 0; j < 4; j++) run_job('1, ScOk);
        run_job(NREQ'(1), ScOk);

        // Engine busy while idle: no grant.
        BUSY = 1'b1;
        req  = rand_mask();
        repeat (5) @(negedge HCLK);
        check("no_gnt_engine_busy", 32'({gnt, START}), 0);
        BUSY = 1'b0;
        req  = '0;
        @(negedge HCLK);

        for (int s = 0; s < 8; s++) run_job(rand_mask(), s);
        for (int j = 0; j < 40; j++) run_job(rand_mask(), int'($urandom_range(0, 7)));

        // Drain timeout: fatal blocks grants until cleared.
        run_job(rand_mask(), ScDrainTo);
        req = '1;
        repeat (8) @(negedge HCLK);
        check("no_gnt_while_fatal", 32'({gnt, START}), 0);
        check("fatal_sticky", 32'(fatal), 1);
        req       = '0;
        fatal_clr = 1'b1;
        @(negedge HCLK);
        fatal_clr = 1'b0;
        check("fatal_cleared", 32'(fatal), 0);
        run_job(rand_mask(), ScOk);

        // Asynchronous reset in the middle of RUN.
        req       = '1;
        stall_req = '1;
        wait_ev(EvStart, 10, "start_before_reset");
        req  = '0;
        BUSY = 1'b1;
        repeat (4) @(negedge HCLK);
        check("stall_in_run", 32'(STALL), 1);
        #2 HRESETN = 1'b0;
        #1 check("async_reset_outputs",
                 32'({gnt, owner, done, status, fatal, START, PURGE, STALL}), 0);
        BUSY      = 1'b0;
        stall_req = '0;
        @(negedge HCLK);
        HRESETN  = 1'b1;
        model_rr = 0;
        @(negedge HCLK);
        run_job('1, ScOk);

        repeat (3) @(negedge HCLK);
        check("scoreboard_drained", 32'(sb.size()), 0);
        summary();
        $finish;
    end

    initial begin
        #2000000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation still running, required finished");
        summary();
        $fatal(1);
    end

endmodule
